// File: rtl/psum_norm_pkg.sv
// Shared definitions for the psum normalizer: FSM state encoding and the
// quotient-to-output shift helper.
package psum_norm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        PUBLISH,
        WAIT,
        DIV,
        OUT
    } state_t;

    // Right shift that maps a full-precision quotient onto the bw-bit output scale.
    function automatic int norm_shift(input int bw, input int bw_psum);
        return bw_psum + 3 - 2 * bw;
    endfunction

    localparam int NORM_SHIFT_DEFAULT = norm_shift(8, 20);

endpackage

// File: rtl/psum_norm_if.sv
// Row-in / result-out handshake bundle of the psum normalizer.
interface psum_norm_if #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2 * bw + 4
) ();

    logic [col*bw_psum-1:0] psum_in;
    logic                   psum_valid;
    logic                   psum_ready;
    logic [col*bw-1:0]      out_data;
    logic [col-1:0]         out_sign;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output psum_in, psum_valid, out_ready,
        input  psum_ready, out_data, out_sign, out_valid
    );

    modport slave (
        input  psum_in, psum_valid, out_ready,
        output psum_ready, out_data, out_sign, out_valid
    );

endinterface

// File: rtl/psum_norm_div.sv
// Serial restoring divider, one quotient bit per cycle; the start cycle already
// performs the first step so back-to-back divisions leave no idle cycle.
module norm_div #(
    parameter int nw = 20,
    parameter int dw = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [nw-1:0] numer,
    input  logic [dw-1:0] denom,
    output logic          busy,
    output logic          done,
    output logic [nw-1:0] quot
);

    localparam int CW = $clog2(nw + 1);

    logic [dw-1:0] rem_q, rem_d;
    logic [nw-1:0] num_q, num_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [dw-1:0] rem_cur;
    logic [nw-1:0] num_cur;
    logic [dw:0]   trial;
    logic [CW-1:0] cnt_next;
    logic          step;

    // Numerator bits shift out of the top while quotient bits shift in at the bottom.
    always_comb begin
        rem_d    = rem_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = 1'b0;
        step     = start || busy_q;
        rem_cur  = start ? '0 : rem_q;
        num_cur  = start ? numer : num_q;
        trial    = {rem_cur, num_cur[nw-1]};
        cnt_next = (start ? '0 : cnt_q) + CW'(1);
        if (step) begin
            if (trial >= {1'b0, denom}) begin
                rem_d = dw'(trial - {1'b0, denom});
                num_d = {num_cur[nw-2:0], 1'b1};
            end else begin
                rem_d = trial[dw-1:0];
                num_d = {num_cur[nw-2:0], 1'b0};
            end
            cnt_d  = cnt_next;
            done   = (cnt_next == CW'(nw));
            busy_d = !done;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q  <= '0;
            num_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            num_q  <= num_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign quot = num_d;

endmodule

// File: rtl/psum_norm.sv
// Normalizes a row of signed partial sums by the combined coarse magnitude sum
// of this core and a remote core, producing saturated magnitudes plus signs.
module psum_norm
    import psum_norm_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2 * bw + 4
) (
    input  logic          clk,
    input  logic          reset,
    psum_norm_if.slave    bus,
    output logic [bw-1:0] sum_out,
    output logic          can_read_out,
    input  logic [bw-1:0] sum_in,
    input  logic          can_read_in,
    output logic          err
);

    localparam int SW    = bw_psum + 3;
    localparam int SHIFT = norm_shift(bw, bw_psum);
    localparam int IW    = (col > 1) ? $clog2(col) : 1;

    state_t              state_q, state_d;
    logic [bw_psum-1:0]  mag_q [col];
    logic [bw_psum-1:0]  mag_d [col];
    logic [bw_psum-1:0]  abs_v [col];
    logic [col-1:0]      sign_q, sign_d;
    logic [bw-1:0]       local_sum_q, local_sum_d;
    logic [SW-1:0]       sum_acc;
    logic [bw-1:0]       sum_out_q, sum_out_d;
    logic                can_read_out_q, can_read_out_d;
    logic                cri_prev_q, cri_prev_d;
    logic                pending_q, pending_d;
    logic                err_q, err_d;
    logic [bw:0]         den_q, den_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [bw-1:0]       res_q [col];
    logic [bw-1:0]       res_d [col];
    logic                div_start, div_busy, div_done;
    logic [bw_psum-1:0]  div_quot;
    logic                remote_toggle, pending_clear;

    function automatic logic [bw-1:0] saturate(input logic [bw_psum-1:0] q);
        logic [bw_psum-1:0] s;
        s = q >> SHIFT;
        if ((s >> bw) != '0) return '1;
        return s[bw-1:0];
    endfunction

    // The row register holds raw psums until SUM, then their magnitudes.
    always_comb begin
        for (int i = 0; i < col; i++)
            abs_v[i] = mag_q[i][bw_psum-1] ? (~mag_q[i] + bw_psum'(1)) : mag_q[i];
    end

    always_comb begin
        state_d        = state_q;
        mag_d          = mag_q;
        sign_d         = sign_q;
        local_sum_d    = local_sum_q;
        sum_out_d      = sum_out_q;
        can_read_out_d = can_read_out_q;
        den_d          = den_q;
        idx_d          = idx_q;
        res_d          = res_q;
        div_start      = 1'b0;
        pending_clear  = 1'b0;
        sum_acc        = '0;
        case (state_q)
            IDLE: begin
                if (bus.psum_valid) begin
                    for (int i = 0; i < col; i++) begin
                        mag_d[i]  = bus.psum_in[i*bw_psum +: bw_psum];
                        sign_d[i] = bus.psum_in[i*bw_psum + bw_psum - 1];
                    end
                    idx_d   = '0;
                    state_d = SUM;
                end
            end
            SUM: begin
                for (int i = 0; i < col; i++)
                    sum_acc = sum_acc + SW'(abs_v[i]);
                local_sum_d = bw'(sum_acc >> (SW - bw));
                mag_d       = abs_v;
                state_d     = PUBLISH;
            end
            PUBLISH: begin
                sum_out_d      = local_sum_q;
                can_read_out_d = ~can_read_out_q;
                state_d        = WAIT;
            end
            WAIT: begin
                if (pending_q) begin
                    den_d         = {1'b0, sum_out_q} + {1'b0, sum_in};
                    pending_clear = 1'b1;
                    state_d       = DIV;
                end
            end
            DIV: begin
                if (den_q == '0) begin
                    for (int i = 0; i < col; i++)
                        res_d[i] = (mag_q[i] == '0) ? '0 : '1;
                    state_d = OUT;
                end else begin
                    div_start = !div_busy;
                    if (div_done) begin
                        res_d[idx_q] = saturate(div_quot);
                        if (idx_q == IW'(col - 1)) begin
                            idx_d   = '0;
                            state_d = OUT;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A remote toggle arriving while one is still unconsumed is an overrun.
    always_comb begin
        remote_toggle = (can_read_in != cri_prev_q);
        cri_prev_d    = can_read_in;
        pending_d     = remote_toggle | (pending_q & ~pending_clear);
        err_d         = err_q | (remote_toggle & pending_q & ~pending_clear);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            mag_q          <= '{default: '0};
            sign_q         <= '0;
            local_sum_q    <= '0;
            sum_out_q      <= '0;
            can_read_out_q <= 1'b0;
            cri_prev_q     <= 1'b0;
            pending_q      <= 1'b0;
            err_q          <= 1'b0;
            den_q          <= '0;
            idx_q          <= '0;
            res_q          <= '{default: '0};
        end else begin
            state_q        <= state_d;
            mag_q          <= mag_d;
            sign_q         <= sign_d;
            local_sum_q    <= local_sum_d;
            sum_out_q      <= sum_out_d;
            can_read_out_q <= can_read_out_d;
            cri_prev_q     <= cri_prev_d;
            pending_q      <= pending_d;
            err_q          <= err_d;
            den_q          <= den_d;
            idx_q          <= idx_d;
            res_q          <= res_d;
        end
    end

    norm_div #(
        .nw(bw_psum),
        .dw(bw + 1)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .numer (mag_q[idx_q]),
        .denom (den_q),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    for (genvar g = 0; g < col; g++) begin : g_pack
        assign bus.out_data[g*bw +: bw] = res_q[g];
    end

    assign bus.psum_ready = (state_q == IDLE);
    assign bus.out_valid  = (state_q == OUT);
    assign bus.out_sign   = sign_q;
    assign sum_out        = sum_out_q;
    assign can_read_out   = can_read_out_q;
    assign err            = err_q;

endmodule

// File: tb/tb_psum_norm.sv
// Directed vector bench for psum_norm: table of rows with hand-computed results,
// plus overrun and mid-division reset sequences.
module tb_psum_norm;

    localparam int COL = 8;
    localparam int BW  = 8;
    localparam int BWP = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] sum_out;
    logic [BW-1:0] sum_in = '0;
    logic          can_read_out;
    logic          can_read_in = 1'b0;
    logic          err;
    logic          exp_cro = 1'b0;
    int            checks = 0;
    int            passes = 0;

    psum_norm_if #(.col(COL), .bw(BW), .bw_psum(BWP)) bus ();

    psum_norm #(.col(COL), .bw(BW), .bw_psum(BWP)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .sum_out      (sum_out),
        .can_read_out (can_read_out),
        .sum_in       (sum_in),
        .can_read_in  (can_read_in),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            fill;
        int            sp_idx;
        int            sp_val;
        logic [BW-1:0] remote;
        logic [BW-1:0] exp_sum;
        logic [BW-1:0] exp_fill;
        logic [BW-1:0] exp_sp;
        logic [COL-1:0] exp_sign;
        int            exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [COL*BWP-1:0] build_row(input vec_t v);
        logic [COL*BWP-1:0] r;
        for (int i = 0; i < COL; i++)
            r[i*BWP +: BWP] = (i == v.sp_idx) ? BWP'(v.sp_val) : BWP'(v.fill);
        return r;
    endfunction

    function automatic logic [63:0] build_exp(input vec_t v);
        logic [63:0] e;
        for (int i = 0; i < COL; i++)
            e[i*BW +: BW] = (i == v.sp_idx) ? v.exp_sp : v.exp_fill;
        return e;
    endfunction

    // Sends one row, optionally announces the remote sum first, and checks the result.
    task automatic apply_stimulus(input int k, input logic toggle_remote, input logic exp_err);
        vec_t v;
        int   cnt;
        v = vecs[k];
        @(negedge clk);
        check_output($sformatf("v%0d_psum_ready", k), 64'(bus.psum_ready), 64'(1));
        sum_in = v.remote;
        if (toggle_remote) can_read_in = ~can_read_in;
        bus.psum_in    = build_row(v);
        bus.psum_valid = 1'b1;
        exp_cro        = ~exp_cro;
        @(posedge clk);
        #1 bus.psum_valid = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk);
            #1 cnt++;
            if (cnt == 2) begin
                check_output($sformatf("v%0d_sum_out_early", k), 64'(sum_out), 64'(v.exp_sum));
                check_output($sformatf("v%0d_can_read_out", k), 64'(can_read_out), 64'(exp_cro));
            end
        end while (!bus.out_valid && cnt < 400);
        check_output($sformatf("v%0d_latency", k), 64'(cnt), 64'(v.exp_lat));
        check_output($sformatf("v%0d_out_data", k), bus.out_data, build_exp(v));
        check_output($sformatf("v%0d_out_sign", k), 64'(bus.out_sign), 64'(v.exp_sign));
        check_output($sformatf("v%0d_sum_out", k), 64'(sum_out), 64'(v.exp_sum));
        check_output($sformatf("v%0d_err", k), 64'(err), 64'(exp_err));
        repeat (2) @(posedge clk);
        #1;
        check_output($sformatf("v%0d_hold_valid", k), 64'(bus.out_valid), 64'(1));
        check_output($sformatf("v%0d_hold_data", k), bus.out_data, build_exp(v));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d_valid_drop", k), 64'(bus.out_valid), 64'(0));
        check_output($sformatf("v%0d_back_idle", k), 64'(bus.psum_ready), 64'(1));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{fill: 32768,  sp_idx: -1, sp_val: 0,       remote: 8,   exp_sum: 8,  exp_fill: 16,  exp_sp: 16,  exp_sign: 8'h00, exp_lat: 163};
        vecs[1] = '{fill: -32768, sp_idx: -1, sp_val: 0,       remote: 8,   exp_sum: 8,  exp_fill: 16,  exp_sp: 16,  exp_sign: 8'hFF, exp_lat: 163};
        vecs[2] = '{fill: 0,      sp_idx: 0,  sp_val: 524287,  remote: 0,   exp_sum: 15, exp_fill: 0,   exp_sp: 255, exp_sign: 8'h00, exp_lat: 163};
        vecs[3] = '{fill: 100,    sp_idx: 3,  sp_val: 0,       remote: 0,   exp_sum: 0,  exp_fill: 255, exp_sp: 0,   exp_sign: 8'h00, exp_lat: 4};
        vecs[4] = '{fill: 1000,   sp_idx: 5,  sp_val: -200000, remote: 20,  exp_sum: 6,  exp_fill: 0,   exp_sp: 60,  exp_sign: 8'h20, exp_lat: 163};
        vecs[5] = '{fill: 262143, sp_idx: -1, sp_val: 0,       remote: 255, exp_sum: 63, exp_fill: 6,   exp_sp: 6,   exp_sign: 8'h00, exp_lat: 163};

        bus.psum_in    = '0;
        bus.psum_valid = 1'b0;
        bus.out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_psum_ready", 64'(bus.psum_ready), 64'(1));
        check_output("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check_output("rst_out_data", bus.out_data, 64'(0));
        check_output("rst_out_sign", 64'(bus.out_sign), 64'(0));
        check_output("rst_sum_out", 64'(sum_out), 64'(0));
        check_output("rst_can_read_out", 64'(can_read_out), 64'(0));
        check_output("rst_err", 64'(err), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 6; k++)
            apply_stimulus(k, 1'b1, 1'b0);

        // Two remote toggles with no row in between: the second one overruns.
        @(negedge clk);
        can_read_in = ~can_read_in;
        @(negedge clk);
        can_read_in = ~can_read_in;
        @(posedge clk);
        #1 check_output("overrun_err", 64'(err), 64'(1));
        apply_stimulus(0, 1'b0, 1'b1);

        // Abort a row partway through division.
        @(negedge clk);
        sum_in         = 8;
        can_read_in    = ~can_read_in;
        bus.psum_in    = build_row(vecs[0]);
        bus.psum_valid = 1'b1;
        @(posedge clk);
        #1 bus.psum_valid = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        reset       = 1'b0;
        can_read_in = 1'b0;
        @(posedge clk);
        #1;
        check_output("midrst_psum_ready", 64'(bus.psum_ready), 64'(1));
        check_output("midrst_can_read_out", 64'(can_read_out), 64'(0));
        check_output("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check_output("midrst_out_data", bus.out_data, 64'(0));
        check_output("midrst_err", 64'(err), 64'(0));
        @(negedge clk);
        reset   = 1'b1;
        exp_cro = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_output("midrst_no_output", 64'(bus.out_valid), 64'(0));
        apply_stimulus(4, 1'b1, 1'b0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/psum_norm.md
PSUM_NORM -- requirements
Module: psum_norm

Interface
REQ-001 Parameter col, default 8, psum elements per row.
REQ-002 Parameter bw, default 8, exchanged-sum and output magnitude width.
REQ-003 Parameter bw_psum, default 2*bw+4, signed psum element width.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 psum_in  in  col*bw_psum  signed two's-complement row; element i at [i*bw_psum +: bw_psum].
REQ-007 psum_valid / psum_ready  in / out  1 / 1  row handshake; transfer when both are high.
REQ-008 sum_out  out  bw  coarse local sum published to the other core.
REQ-009 can_read_out  out  1  toggles once per published sum_out.
REQ-010 sum_in  in  bw  coarse remote sum from the other core.
REQ-011 can_read_in  in  1  remote toggle flag, already synchronized into clk.
REQ-012 out_data  out  col*bw  normalized magnitudes; element i at [i*bw +: bw].
REQ-013 out_sign  out  col  sign bit of each source element.
REQ-014 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-015 err  out  1  sticky remote-toggle overrun flag.

Function
REQ-016 FSM states: IDLE, SUM, PUBLISH, WAIT, DIV, OUT.
REQ-017 IDLE: psum_ready=1; on transfer, capture the row and the sign bits, then go to SUM. psum_ready=0 in every other state.
REQ-018 SUM (1 cycle): N_i=|psum_i| as bw_psum-bit unsigned (-2^(bw_psum-1) maps to 2^(bw_psum-1)); local_sum = sum of all N_i, bw_psum+3 bits, no overflow possible.
REQ-019 PUBLISH (1 cycle): sum_out <= local_sum[bw_psum+2 -: bw]; can_read_out inverts; sum_out is valid 2 cycles after the accept cycle and holds until the next PUBLISH.
REQ-020 Remote detect: each cycle where can_read_in differs from its registered previous value sets pending.
REQ-021 WAIT: when pending=1, latch D = sum_out + sum_in (bw+1 bits, unsigned), clear pending, go to DIV. A pending set before WAIT is honoured on the first WAIT cycle.
REQ-022 A remote toggle while pending=1 and not being cleared in that cycle sets err; pending stays 1.
REQ-023 DIV: serial restoring division, one element at a time, i=0..col-1, bw_psum cycles per element. Q_i = floor(N_i/D). out_i = min(2^bw-1, Q_i >> (bw_psum+3-2*bw)).
REQ-024 D==0: skip the division; out_i = 0 if N_i==0, else 2^bw-1; leave DIV after 1 cycle.
REQ-025 OUT: out_valid=1 with out_data/out_sign stable until out_ready; on transfer, go to IDLE; out_valid=0 in every other state.
REQ-026 Total latency at default parameters, D!=0, remote already pending, out_ready=1: accept to out_valid = 3 + col*bw_psum = 163 cycles.

Reset
REQ-027 reset low at a clk edge forces IDLE with these values: psum_ready=1 after release, out_valid=0, out_data=0, out_sign=0, sum_out=0, can_read_out=0, pending=0, previous can_read_in=0, err=0.
REQ-028 Reset mid-operation (any state) abandons the row with no partial output; both cores are reset together.

Structure
REQ-029 Shared package psum_norm_pkg holds the FSM state enum and the shift constant bw_psum+3-2*bw.
REQ-030 The single sub-module norm_div is the serial restoring divider: start/busy/done, bw_psum-bit numerator, (bw+1)-bit divisor.

Verification
REQ-031 All psum=32768, sum_in=8, remote pending -> sum_out=8, D=16, every out_i=16, out_sign=0.
REQ-032 All psum=-32768, same remote -> out_i=16, out_sign=all 1s.
REQ-033 psum_0=524287, rest 0, sum_in=0 -> sum_out=15, out_0=255 (saturated), rest 0.
REQ-034 All psum=100, elem 3=0, sum_in=0 -> D=0; out_i=255 except out_3=0; DIV lasts 1 cycle.
REQ-035 Remote toggle in IDLE, then a second toggle before WAIT -> err=1; pending=1 on WAIT entry; result still produced.
REQ-036 reset low mid-DIV -> next cycle IDLE, can_read_out=0, out_valid=0; a following row processes normally.
